// File: rtl/pipelined_adder_pkg.sv
// Shared definitions for the pipelined add/subtract unit and future ALU/accumulator blocks.
// Holds the opcode encoding, segment-width derivation, config legality and the one-bit full adder.
package pipelined_adder_pkg;

    typedef enum logic {
        OP_ADD = 1'b0,
        OP_SUB = 1'b1
    } op_e;

    typedef struct packed {
        logic cout;
        logic sum;
    } fa_t;

    function automatic int seg_width(input int width, input int stages);
        return width / stages;
    endfunction

    function automatic bit legal_cfg(input int width, input int stages);
        return (stages >= 1) && (width >= stages) && ((width % stages) == 0);
    endfunction

    function automatic fa_t full_add(input logic a, input logic b, input logic cin);
        fa_t r;
        r.sum  = a ^ b ^ cin;
        r.cout = (a & b) | (cin & (a ^ b));
        return r;
    endfunction

endpackage

// File: rtl/pipelined_adder_segment.sv
// SEG-bit combinational ripple segment built from the shared full adder.
// msb_cin is the carry into the top bit, needed for signed overflow in the last segment.
module pipelined_adder_segment
    import pipelined_adder_pkg::*;
#(
    parameter int SEG = 8
) (
    input  logic [SEG-1:0] a,
    input  logic [SEG-1:0] b,
    input  logic           cin,
    output logic [SEG-1:0] s,
    output logic           cout,
    output logic           msb_cin
);

    logic [SEG:0] c;
    fa_t          fa;

    always_comb begin
        c    = '0;
        s    = '0;
        fa   = '0;
        c[0] = cin;
        for (int i = 0; i < SEG; i++) begin
            fa     = full_add(a[i], b[i], c[i]);
            s[i]   = fa.sum;
            c[i+1] = fa.cout;
        end
    end

    assign cout    = c[SEG];
    assign msb_cin = c[SEG-1];

endmodule

// File: rtl/pipelined_adder.sv
// WIDTH-bit add/subtract unit with the carry chain split into STAGES registered segments.
// Ready/valid on both sides; a stalled output freezes the whole pipeline.
module pipelined_adder
    import pipelined_adder_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_cin,
    input  logic             in_sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout,
    output logic             out_ovf
);

    localparam int SEG = seg_width(WIDTH, STAGES);

    if (!legal_cfg(WIDTH, STAGES)) begin : g_bad_cfg
        $error("pipelined_adder: WIDTH=%0d must be >= STAGES=%0d and a multiple of it", WIDTH, STAGES);
    end

    op_e  op;
    logic advance;
    logic accept;

    // vld_pipe[0] is the beat entering stage 0; vld_pipe[k] has finished stage k-1.
    logic [STAGES:0]                  vld_pipe;
    logic [STAGES:1]                  vld_pipe_d, vld_pipe_q;

    // Row k holds a beat that has completed stage k; row STAGES-1 is the output register.
    logic [STAGES-1:0][WIDTH-1:0]     a_d, a_q, b_d, b_q, s_d, s_q;
    logic [STAGES-1:0]                c_d, c_q;
    logic                             ovf_d, ovf_q;

    logic [STAGES-1:0][WIDTH-1:0]     a_stg, b_stg, s_stg;
    logic [STAGES-1:0]                c_stg;
    logic [STAGES-1:0][SEG-1:0]       seg_s;
    logic [STAGES-1:0]                seg_cout, seg_msb_cin;
    logic                             unused_skew;

    assign op        = in_sub ? OP_SUB : OP_ADD;
    assign out_valid = vld_pipe[STAGES];
    assign advance   = !out_valid || out_ready;
    assign in_ready  = advance;
    assign accept    = in_valid && in_ready;

    assign vld_pipe[0]        = accept;
    assign vld_pipe[STAGES:1] = vld_pipe_q;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        if (k == 0) begin : g_head
            assign a_stg[k] = in_a;
            assign b_stg[k] = (op == OP_SUB) ? ~in_b : in_b;
            assign s_stg[k] = '0;
            assign c_stg[k] = (op == OP_SUB) ? 1'b1 : in_cin;
        end else begin : g_body
            assign a_stg[k] = a_q[k-1];
            assign b_stg[k] = b_q[k-1];
            assign s_stg[k] = s_q[k-1];
            assign c_stg[k] = c_q[k-1];
        end

        pipelined_adder_segment #(.SEG(SEG)) u_seg (
            .a       (a_stg[k][k*SEG +: SEG]),
            .b       (b_stg[k][k*SEG +: SEG]),
            .cin     (c_stg[k]),
            .s       (seg_s[k]),
            .cout    (seg_cout[k]),
            .msb_cin (seg_msb_cin[k])
        );
    end

    // Consumed operand bits and the last row's skew regs are dead by construction.
    assign unused_skew = ^{a_stg[STAGES-1], b_stg[STAGES-1], a_q[STAGES-1], b_q[STAGES-1], seg_msb_cin};

    always_comb begin
        vld_pipe_d = vld_pipe_q;
        a_d        = a_q;
        b_d        = b_q;
        s_d        = s_q;
        c_d        = c_q;
        ovf_d      = ovf_q;
        if (advance) begin
            vld_pipe_d = vld_pipe[STAGES-1:0];
            for (int k = 0; k < STAGES - 1; k++) begin
                a_d[k]                = a_stg[k];
                b_d[k]                = b_stg[k];
                s_d[k]                = s_stg[k];
                s_d[k][k*SEG +: SEG]  = seg_s[k];
                c_d[k]                = seg_cout[k];
            end
            // Output registers keep their last result across bubbles.
            if (vld_pipe[STAGES-1]) begin
                s_d[STAGES-1]                        = s_stg[STAGES-1];
                s_d[STAGES-1][(STAGES-1)*SEG +: SEG] = seg_s[STAGES-1];
                c_d[STAGES-1]                        = seg_cout[STAGES-1];
                ovf_d = seg_msb_cin[STAGES-1] ^ seg_cout[STAGES-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_pipe_q <= '0;
            a_q        <= '0;
            b_q        <= '0;
            s_q        <= '0;
            c_q        <= '0;
            ovf_q      <= 1'b0;
        end else begin
            vld_pipe_q <= vld_pipe_d;
            a_q        <= a_d;
            b_q        <= b_d;
            s_q        <= s_d;
            c_q        <= c_d;
            ovf_q      <= ovf_d;
        end
    end

    assign out_sum  = s_q[STAGES-1];
    assign out_cout = c_q[STAGES-1];
    assign out_ovf  = ovf_q;

endmodule
